// File: rtl/if_id_pipe_buffer.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// It also carries a registered redirect path from ID back to IF.
module if_id_pipe_buffer #(
  parameter int                    CORE         = 0,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDRESS_BITS = 20,
  parameter logic [DATA_WIDTH-1:0] NOP          = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  logic [DATA_WIDTH-1:0]   if_instruction,
  input  logic [ADDRESS_BITS-1:0] if_inst_PC,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [DATA_WIDTH-1:0]   id_instruction,
  output logic [ADDRESS_BITS-1:0] id_inst_PC,
  input  logic                    flush,
  input  logic                    id_redirect,
  input  logic [ADDRESS_BITS-1:0] id_redirect_target,
  input  logic [1:0]              id_next_PC_select,
  output logic                    if_redirect,
  output logic [ADDRESS_BITS-1:0] if_redirect_target,
  output logic [1:0]              if_next_PC_select,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state, next_state;
  logic [DATA_WIDTH-1:0]   head_instr, skid_instr;
  logic [ADDRESS_BITS-1:0] head_pc, skid_pc;
  logic                    push, pop;
  logic                    load_head_in, load_head_skid, load_skid;
  logic                    unused_core;

  assign unused_core = (CORE != 0);

  // Handshake flags decode the registered state only, so id_ready never reaches if_ready.
  assign if_ready  = (state != FULL);
  assign id_valid  = (state == ONE) || (state == FULL);
  assign occupancy = state;
  assign push      = if_valid & if_ready;
  assign pop       = id_valid & id_ready;

  assign id_instruction = id_valid ? head_instr : NOP;
  assign id_inst_PC     = id_valid ? head_pc : '0;

  always_comb begin
    next_state     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            next_state   = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            next_state     = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Payload storage needs no reset; the output mux hides it whenever id_valid is low.
  always_ff @(posedge clock) begin
    if (load_head_in) begin
      head_instr <= if_instruction;
      head_pc    <= if_inst_PC;
    end else if (load_head_skid) begin
      head_instr <= skid_instr;
      head_pc    <= skid_pc;
    end
    if (load_skid) begin
      skid_instr <= if_instruction;
      skid_pc    <= if_inst_PC;
    end
  end

  // The redirect path ignores stall and flush; it is a plain one-cycle delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_redirect        <= 1'b0;
      if_redirect_target <= '0;
      if_next_PC_select  <= 2'b00;
    end else begin
      if_redirect        <= id_redirect;
      if_redirect_target <= id_redirect_target;
      if_next_PC_select  <= id_next_PC_select;
    end
  end

endmodule

// File: doc/if_id_pipe_buffer.md
Name: if_id_pipe_buffer

Overview:
Parametrised IF/ID pipeline stage with a valid/ready handshake and a 2-entry skid buffer. The fetch stage can stall, and the decode stage can apply backpressure without a combinational ready path. Also carries a registered redirect path (branch/JAL/JALR target and next-PC select) from ID back to IF. Has a synchronous flush for mispredict squash.

Parameters:
CORE, 0, core index; informational only, no behavioural effect
DATA_WIDTH, 32, instruction width
ADDRESS_BITS, 20, PC / target width
NOP, 32'h00000013, value driven on id_instruction when id_valid=0 (RISC-V addi x0,x0,0)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  fetch presents an instruction
if_ready  out  1  buffer can accept; registered (state != FULL)
if_instruction  in  DATA_WIDTH  fetched instruction
if_inst_PC  in  ADDRESS_BITS  PC of fetched instruction
id_valid  out  1  head entry valid
id_ready  in  1  decode consumes head this cycle
id_instruction  out  DATA_WIDTH  head instruction, or NOP when !id_valid
id_inst_PC  out  ADDRESS_BITS  head PC, or 0 when !id_valid
flush  in  1  discard all buffered entries
id_redirect  in  1  ID requests PC redirect
id_redirect_target  in  ADDRESS_BITS  redirect target
id_next_PC_select  in  2  next-PC mux select from ID
if_redirect  out  1  id_redirect delayed 1 cycle
if_redirect_target  out  ADDRESS_BITS  id_redirect_target delayed 1 cycle
if_next_PC_select  out  2  id_next_PC_select delayed 1 cycle
occupancy  out  2  entries held, 0..2

Behaviour:
- Storage: head entry {instr, PC} and skid entry {instr, PC}. State is EMPTY(0), ONE(1) or FULL(2); occupancy equals the entry count.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready is high in EMPTY and ONE. It is a registered function of state, with no combinational path from id_ready.
- id_valid is high in ONE and FULL. Outputs show the head entry and are NOP / 0 when id_valid=0.
- EMPTY: push -> ONE, head<=input. Otherwise stay.
- ONE: push&pop -> ONE, head<=input. push only -> FULL, skid<=input. pop only -> EMPTY. Neither -> hold.
- FULL: pop -> ONE, head<=skid. No pop -> hold. push is impossible (if_ready=0).
- Order is preserved: the head is always the older entry.
- Entries are never duplicated or dropped except on flush/reset.
- Priority order: reset > flush > normal handshake.
- flush=1: next state EMPTY. The same-cycle if_valid input is discarded even though if_ready may be high. The pop is ignored, so the consumer must also squash.
  - Next cycle: id_valid=0, if_ready=1, occupancy=0.
- Redirect path is a plain 1-cycle register, independent of stall and flush: if_redirect / if_redirect_target / if_next_PC_select <= id_* every cycle.
- Reset values:
  - state EMPTY; occupancy 0
  - id_valid 0; if_ready 1
  - id_instruction NOP; id_inst_PC 0
  - if_redirect 0; if_redirect_target 0; if_next_PC_select 0
  - storage contents don't-care
- Reset asserted mid-operation takes effect on that edge, regardless of flush/push/pop.
- Latency: 1 cycle from push to id_valid. Full throughput of 1 instr/cycle when id_ready held high.
- X-safety: id_* payload outputs are never X when id_valid=0.

Test Plan:
- Reset, then release with if_valid=0 -> id_valid=0, id_instruction=32'h00000013, id_inst_PC=0, if_ready=1, occupancy=0, if_next_PC_select=0.
- Stream PCs 0x00,0x04,0x08 with instrs 0xA,0xB,0xC and id_ready=1 -> id outputs show them in order 1 cycle later, occupancy stays 1, if_ready stays 1.
- id_ready=0 while pushing 0xA,0xB -> occupancy 2, if_ready=0 next cycle, 0xC held off. Then id_ready=1 -> drains 0xA, 0xB, 0xC in order with no loss or duplicate.
- FULL with flush=1, if_valid=1 (instr 0xD) -> next cycle occupancy=0, id_valid=0, id_instruction=NOP. 0xD is not captured.
- id_redirect=1, target=0x1234, select=2'b10 for one cycle during a stall -> if_redirect=1, if_redirect_target=0x1234, if_next_PC_select=2'b10 exactly 1 cycle later, then 0. Buffer contents unaffected.
- reset=1 and flush=1 in the same cycle while FULL with pending push -> all outputs at reset values next cycle.
